remote_dest_scoreboard: RTL

- Tracks destination register IDs of outstanding long-latency writes (remote loads, iterative fdiv/fsqrt) for the vanilla core issue stage.
- Holds a small fully-associative table of pending IDs.
- Compares every issuing instruction's source and destination IDs against all pending entries through an equality_matrix instance.
- Raises a stall on RAW/WAW hazard or when the table is full; frees entries when the write-back returns.

---
 rtl/vanilla_scoreboard_pkg.sv | 24 ++
 rtl/remote_dest_scoreboard_if.sv | 35 +++
 rtl/equality_matrix.sv | 19 +
 rtl/remote_dest_scoreboard.sv | 107 ++++++++++
 4 files changed

// File: rtl/vanilla_scoreboard_pkg.sv
// Shared types and helpers for the remote destination scoreboard.
//   scoreboard_entry_s : one tracked destination (valid + register ID).
//   lowest_free        : index of the lowest set bit, sb_max_entries_lp if none.
package vanilla_scoreboard_pkg;

  // Register ID width carried by a table entry; the scoreboard's width_p
  // must match it.
  localparam int sb_id_width_lp   = 5;
  // Upper bound on table depth accepted by lowest_free.
  localparam int sb_max_entries_lp = 32;

  typedef struct packed {
    logic                       valid;
    logic [sb_id_width_lp-1:0]  id;
  } scoreboard_entry_s;

  // Priority encoder: the scan runs high-to-low so the lowest set bit wins.
  function automatic int lowest_free(input logic [sb_max_entries_lp-1:0] free_v);
    lowest_free = sb_max_entries_lp;
    for (int i = sb_max_entries_lp-1; i >= 0; i--)
      if (free_v[i]) lowest_free = i;
  endfunction

endpackage

// File: rtl/remote_dest_scoreboard_if.sv
// Issue / write-back bundle of the remote destination scoreboard.
//   master : issue stage + write-back side (drives issue_*, return_*).
//   slave  : scoreboard (drives stall_o, full_o, empty_o, count_o, err_o).
interface remote_dest_scoreboard_if #(
  parameter int width_p       = 5,
  parameter int num_entries_p = 8,
  parameter int num_src_p     = 3
);
  localparam int cnt_w_lp = $clog2(num_entries_p+1);

  logic                               issue_v_i;
  logic [num_src_p-1:0]               issue_src_v_i;
  logic [num_src_p-1:0][width_p-1:0]  issue_src_i;
  logic                               issue_dest_v_i;
  logic [width_p-1:0]                 issue_dest_i;
  logic                               stall_o;
  logic                               return_v_i;
  logic [width_p-1:0]                 return_id_i;
  logic                               full_o;
  logic                               empty_o;
  logic [cnt_w_lp-1:0]                count_o;
  logic                               err_o;

  modport master (
    output issue_v_i, issue_src_v_i, issue_src_i, issue_dest_v_i, issue_dest_i,
           return_v_i, return_id_i,
    input  stall_o, full_o, empty_o, count_o, err_o
  );

  modport slave (
    input  issue_v_i, issue_src_v_i, issue_src_i, issue_dest_v_i, issue_dest_i,
           return_v_i, return_id_i,
    output stall_o, full_o, empty_o, count_o, err_o
  );
endinterface

// File: rtl/equality_matrix.sv
// All-pairs equality compare: eq_o[c][r] = (col_i[c] == row_i[r]).
//   col_i : num_col_p IDs checked this cycle.
//   row_i : num_row_p stored IDs.
//   eq_o  : one match bit per (column, row) pair.
module equality_matrix #(
  parameter int width_p   = 5,
  parameter int num_col_p = 4,
  parameter int num_row_p = 8
) (
  input  logic [num_col_p-1:0][width_p-1:0]   col_i,
  input  logic [num_row_p-1:0][width_p-1:0]   row_i,
  output logic [num_col_p-1:0][num_row_p-1:0] eq_o
);
  for (genvar c = 0; c < num_col_p; c++) begin : g_col
    for (genvar r = 0; r < num_row_p; r++) begin : g_row
      assign eq_o[c][r] = (col_i[c] == row_i[r]);
    end
  end
endmodule

// File: rtl/remote_dest_scoreboard.sv
// Scoreboard of outstanding long-latency destination registers.
// Stalls issue on RAW/WAW against pending IDs or when the table is full;
// frees entries on write-back.
//   clk_i, reset_i : clock, synchronous active-high reset.
//   sb_if          : issue/return inputs, stall/full/empty/count/err outputs.
module remote_dest_scoreboard
  import vanilla_scoreboard_pkg::*;
#(
  parameter int width_p       = sb_id_width_lp,
  parameter int num_entries_p = 8,
  parameter int num_src_p     = 3,
  parameter int ignore_zero_p = 1
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  remote_dest_scoreboard_if.slave sb_if
);
  localparam int cnt_w_lp = $clog2(num_entries_p+1);
  localparam int dest_col_lp = num_src_p;

  scoreboard_entry_s [num_entries_p-1:0] tbl_q, tbl_d;
  logic [cnt_w_lp-1:0] count_q, count_d;
  logic                err_q, err_d;

  logic [num_entries_p-1:0][width_p-1:0]   row_ids;
  logic [num_src_p:0][width_p-1:0]         cols;
  logic [num_src_p:0][num_entries_p-1:0]   eq;

  // Columns are {dest, src[num_src_p-1:0]}: dest sits in the top column.
  assign cols = {sb_if.issue_dest_i, sb_if.issue_src_i};
  always_comb
    for (int e = 0; e < num_entries_p; e++) row_ids[e] = tbl_q[e].id;

  equality_matrix #(
    .width_p(width_p), .num_col_p(num_src_p+1), .num_row_p(num_entries_p)
  ) u_eq (.col_i(cols), .row_i(row_ids), .eq_o(eq));

  logic                     ret_eff, return_hit, alloc_need, dest_zero;
  logic                     raw, waw, full_stall, stall, alloc_do, full;
  logic [num_entries_p-1:0] ret_match, eff_valid;
  logic [sb_max_entries_lp-1:0] free_v;
  int                       alloc_idx;

  assign full = (count_q == cnt_w_lp'(num_entries_p));
  assign dest_zero  = (ignore_zero_p != 0) && (sb_if.issue_dest_i == '0);
  // ID 0 returns are dropped entirely: no clear, no error.
  assign ret_eff    = sb_if.return_v_i &
                      ~((ignore_zero_p != 0) && (sb_if.return_id_i == '0));
  assign alloc_need = sb_if.issue_dest_v_i & ~dest_zero;

  always_comb begin
    ret_match = '0;
    eff_valid = '0;
    free_v    = '0;
    raw       = 1'b0;
    waw       = 1'b0;
    for (int e = 0; e < num_entries_p; e++) begin
      ret_match[e] = tbl_q[e].valid & ret_eff & (tbl_q[e].id == sb_if.return_id_i);
      // A same-cycle return bypasses: the entry no longer blocks issue.
      eff_valid[e] = tbl_q[e].valid & ~ret_match[e];
      free_v[e]    = ~eff_valid[e];
      for (int s = 0; s < num_src_p; s++)
        if (eq[s][e] && sb_if.issue_src_v_i[s] && eff_valid[e] &&
            !((ignore_zero_p != 0) && (sb_if.issue_src_i[s] == '0)))
          raw = 1'b1;
      if (eq[dest_col_lp][e] && alloc_need && eff_valid[e]) waw = 1'b1;
    end
  end

  assign return_hit = |ret_match;
  assign full_stall = alloc_need & full & ~return_hit;
  assign stall      = sb_if.issue_v_i & (raw | waw | full_stall);
  assign alloc_do   = sb_if.issue_v_i & ~stall & alloc_need;
  assign alloc_idx  = lowest_free(free_v);

  always_comb begin
    tbl_d = tbl_q;
    for (int e = 0; e < num_entries_p; e++) begin
      if (ret_match[e]) tbl_d[e].valid = 1'b0;
      // Allocation is applied after the clear so a freed slot is reusable.
      if (alloc_do && (e == alloc_idx)) begin
        tbl_d[e].valid = 1'b1;
        tbl_d[e].id    = sb_if.issue_dest_i;
      end
    end
    count_d = count_q + cnt_w_lp'(alloc_do) - cnt_w_lp'(return_hit);
    err_d   = err_q | (ret_eff & ~return_hit);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tbl_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      tbl_q   <= tbl_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign sb_if.stall_o = stall;
  assign sb_if.full_o  = full;
  assign sb_if.empty_o = (count_q == '0);
  assign sb_if.count_o = count_q;
  assign sb_if.err_o   = err_q;
endmodule
